regfile_sb: RTL and testbench

- Parametrised successor of the 2-read/1-write CPU register file, for the pipelined RISC-V core.
- Adds registered reads with enable-hold, and a hardware zero-register option.
- Adds a reset-driven sequential clear sweep, so no `initial` block is needed.
- Adds a per-register busy scoreboard, which the hazard unit uses to stall on pending writebacks.

---
 rtl/regfile_sb_if.sv | 28 ++
 rtl/regfile_sb.sv | 72 +++++++
 tb/tb_regfile_sb.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: write, read, scoreboard-mark and status signals of the regfile_sb register file
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en1;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic              rd_en2;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data2;
    logic              mark_en;
    logic [ADDR_W-1:0] mark_addr;
    logic              busy1;
    logic              busy2;
    logic              ready;
    modport master (
        output wr_en, wr_addr, wr_data, rd_en1, rd_addr1, rd_en2, rd_addr2, mark_en, mark_addr,
        input  rd_data1, rd_data2, busy1, busy2, ready
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en1, rd_addr1, rd_en2, rd_addr2, mark_en, mark_addr,
        output rd_data1, rd_data2, busy1, busy2, ready
    );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with clear sweep and busy scoreboard; REGFILE_BYPASS_EN selects write-first reads
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    typedef enum logic {CLEAR, RUN} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              run, wr_ok, mark_ok, hit1, hit2, zero1, zero2;
    assign run     = state_q == RUN;
    assign wr_ok   = run && bus.wr_en && !(ZERO_REG != 0 && bus.wr_addr == '0);
    assign mark_ok = run && bus.mark_en && !(ZERO_REG != 0 && bus.mark_addr == '0);
    assign hit1    = BYPASS && wr_ok && bus.wr_addr == bus.rd_addr1;
    assign hit2    = BYPASS && wr_ok && bus.wr_addr == bus.rd_addr2;
    assign zero1   = ZERO_REG != 0 && bus.rd_addr1 == '0;
    assign zero2   = ZERO_REG != 0 && bus.rd_addr2 == '0;
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        if (!run) begin
            ptr_d   = ptr_q + 1'b1;
            state_d = &ptr_q ? RUN : CLEAR;
        end else begin
            if (wr_ok) busy_d[bus.wr_addr] = 1'b0;
            // mark after clear so a same-cycle reissue keeps the register busy
            if (mark_ok) busy_d[bus.mark_addr] = 1'b1;
            if (bus.rd_en1) rd1_d = zero1 ? '0 : hit1 ? bus.wr_data : mem_q[bus.rd_addr1];
            if (bus.rd_en2) rd2_d = zero2 ? '0 : hit2 ? bus.wr_data : mem_q[bus.rd_addr2];
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
            busy_q  <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && !run) mem_q[ptr_q] <= '0;
        else if (!rst && wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
    end
    assign bus.rd_data1 = rd1_q;
    assign bus.rd_data2 = rd2_q;
    assign bus.busy1    = run && busy_q[bus.rd_addr1] && !hit1;
    assign bus.busy2    = run && busy_q[bus.rd_addr2] && !hit2;
    assign bus.ready    = run;
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed and randomized checks of regfile_sb against an array-based reference model
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    int total = 0;
    int bad = 0;
    logic [DW-1:0] mem_m [N];
    logic          busy_m [N];
    logic [DW-1:0] rd1_m = '0, rd2_m = '0;
    int            clr = N;

    task automatic idle();
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.rd_en1 = 0; bus.rd_addr1 = 0; bus.rd_en2 = 0; bus.rd_addr2 = 0;
        bus.mark_en = 0; bus.mark_addr = 0;
    endtask

    // advance model by the current inputs, then one clock edge
    task automatic cyc();
        logic wz;
        wz = bus.wr_en && bus.wr_addr != 0;
        if (rst) begin
            clr = N; rd1_m = '0; rd2_m = '0;
            for (int i = 0; i < N; i++) begin mem_m[i] = '0; busy_m[i] = 1'b0; end
        end else if (clr > 0) begin
            clr--;
        end else begin
            if (bus.rd_en1) rd1_m = bus.rd_addr1 == 0 ? '0 : (BYP && wz && bus.wr_addr == bus.rd_addr1) ? bus.wr_data : mem_m[bus.rd_addr1];
            if (bus.rd_en2) rd2_m = bus.rd_addr2 == 0 ? '0 : (BYP && wz && bus.wr_addr == bus.rd_addr2) ? bus.wr_data : mem_m[bus.rd_addr2];
            if (wz) begin mem_m[bus.wr_addr] = bus.wr_data; busy_m[bus.wr_addr] = 1'b0; end
            if (bus.mark_en && bus.mark_addr != 0) busy_m[bus.mark_addr] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_exp(input logic [AW-1:0] a);
        return clr == 0 && busy_m[a] && !(BYP && bus.wr_en && bus.wr_addr == a && a != 0);
    endfunction

    task automatic test_reset();
        int n;
        idle();
        rst = 1; cyc(); rst = 0;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", bus.ready); end
        total++; if (bus.rd_data1 !== '0) begin bad++; $display("FAIL reset_rd1 got=%h exp=0", bus.rd_data1); end
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin cyc(); n++; end
        total++; if (n != 32) begin bad++; $display("FAIL sweep_len got=%0d exp=32", n); end
        for (int a = 0; a < N; a++) begin
            bus.rd_en1 = 1; bus.rd_addr1 = AW'(a); bus.rd_en2 = 1; bus.rd_addr2 = AW'(N - 1 - a);
            cyc();
            total++; if (bus.rd_data1 !== '0 || bus.rd_data2 !== '0) begin bad++; $display("FAIL clear_read a=%0d got=%h/%h exp=0", a, bus.rd_data1, bus.rd_data2); end
        end
        idle();
        rst = 1; cyc(); rst = 0;
        repeat (10) cyc();
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL midsweep_ready got=%b exp=0", bus.ready); end
        rst = 1; cyc(); rst = 0;
        total++; if (bus.ready !== 1'b0) begin bad++; $display("FAIL rerst_ready got=%b exp=0", bus.ready); end
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin cyc(); n++; end
        total++; if (n != 32) begin bad++; $display("FAIL resweep_len got=%0d exp=32", n); end
    endtask

    task automatic test_latency();
        idle();
        bus.wr_en = 1; bus.wr_addr = 5; bus.wr_data = 32'hDEADBEEF;
        cyc(); idle();
        bus.rd_en1 = 1; bus.rd_addr1 = 5;
        cyc();
        total++; if (bus.rd_data1 !== 32'hDEADBEEF || rd1_m !== 32'hDEADBEEF) begin bad++; $display("FAIL read_lat got=%h exp=deadbeef", bus.rd_data1); end
        bus.rd_en1 = 0; bus.rd_addr1 = 6;
        cyc(); cyc();
        total++; if (bus.rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_hold got=%h exp=deadbeef", bus.rd_data1); end
    endtask

    task automatic test_zero();
        idle();
        bus.wr_en = 1; bus.wr_addr = 0; bus.wr_data = 32'h12345678;
        cyc(); idle();
        bus.rd_en1 = 1; bus.rd_en2 = 1;
        cyc();
        total++; if (bus.rd_data1 !== '0 || bus.rd_data2 !== '0) begin bad++; $display("FAIL zero_read got=%h/%h exp=0", bus.rd_data1, bus.rd_data2); end
        idle(); bus.mark_en = 1; bus.mark_addr = 0;
        cyc(); idle(); #1;
        total++; if (bus.busy1 !== 1'b0 || bus.busy2 !== 1'b0) begin bad++; $display("FAIL zero_busy got=%b%b exp=00", bus.busy1, bus.busy2); end
    endtask

    task automatic test_scoreboard();
        idle(); bus.mark_en = 1; bus.mark_addr = 7;
        cyc(); idle(); bus.rd_addr1 = 7; #1;
        total++; if (bus.busy1 !== 1'b1) begin bad++; $display("FAIL mark_busy got=%b exp=1", bus.busy1); end
        bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 32'h77; #1;
        total++; if (bus.busy1 !== !BYP) begin bad++; $display("FAIL wr_cycle_busy got=%b exp=%b", bus.busy1, !BYP); end
        cyc(); idle(); bus.rd_addr1 = 7; #1;
        total++; if (bus.busy1 !== 1'b0) begin bad++; $display("FAIL wb_clear got=%b exp=0", bus.busy1); end
        bus.mark_en = 1; bus.mark_addr = 7; bus.wr_en = 1; bus.wr_addr = 7; bus.wr_data = 32'h78;
        cyc(); idle(); bus.rd_addr1 = 7; bus.rd_addr2 = 7; #1;
        total++; if (bus.busy1 !== 1'b1 || bus.busy2 !== 1'b1) begin bad++; $display("FAIL set_wins got=%b%b exp=11", bus.busy1, bus.busy2); end
        bus.wr_en = 1; bus.wr_addr = 7;
        cyc(); idle();
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp;
        idle(); bus.wr_en = 1; bus.wr_addr = 3; bus.wr_data = 32'h11;
        cyc();
        bus.wr_data = 32'hA5A5A5A5; bus.rd_en1 = 1; bus.rd_addr1 = 3; bus.rd_en2 = 1; bus.rd_addr2 = 3;
        cyc(); idle();
        exp = BYP ? 32'hA5A5A5A5 : 32'h11;
        total++; if (bus.rd_data1 !== exp || bus.rd_data2 !== exp) begin bad++; $display("FAIL bypass got=%h/%h exp=%h", bus.rd_data1, bus.rd_data2, exp); end
        bus.rd_en1 = 1; bus.rd_addr1 = 3;
        cyc(); idle();
        total++; if (bus.rd_data1 !== 32'hA5A5A5A5) begin bad++; $display("FAIL post_bypass got=%h exp=a5a5a5a5", bus.rd_data1); end
    endtask

    task automatic test_lockout();
        int n;
        idle(); bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'hCAFE;
        cyc(); idle();
        rst = 1; cyc(); rst = 0;
        bus.wr_en = 1; bus.wr_addr = 9; bus.wr_data = 32'hFFFF; bus.mark_en = 1; bus.mark_addr = 9;
        bus.rd_en1 = 1; bus.rd_addr1 = 9;
        n = 0;
        while (bus.ready !== 1'b1 && n < 100) begin
            #1;
            if (bus.rd_data1 !== '0 || bus.busy1 !== 1'b0) begin bad++; $display("FAIL clear_out got=%h busy=%b exp=0", bus.rd_data1, bus.busy1); end
            cyc(); n++;
        end
        total++; if (n != 32) begin bad++; $display("FAIL lock_sweep got=%0d exp=32", n); end
        idle(); bus.rd_en1 = 1; bus.rd_addr1 = 9; #1;
        total++; if (bus.busy1 !== 1'b0) begin bad++; $display("FAIL lock_busy got=%b exp=0", bus.busy1); end
        cyc();
        total++; if (bus.rd_data1 !== '0 || rd1_m !== '0) begin bad++; $display("FAIL lock_data got=%h exp=0", bus.rd_data1); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom % 400) == 0;
            bus.wr_en = $urandom % 2; bus.wr_data = $urandom;
            bus.wr_addr = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.rd_en1 = $urandom % 4 != 0; bus.rd_addr1 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.rd_en2 = $urandom % 4 != 0; bus.rd_addr2 = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            bus.mark_en = $urandom % 3 == 0; bus.mark_addr = AW'($urandom_range(0, 7));
            #1;
            total++; if (bus.busy1 !== busy_exp(bus.rd_addr1) || bus.busy2 !== busy_exp(bus.rd_addr2)) begin
                bad++; $display("FAIL rnd_busy i=%0d got=%b%b exp=%b%b", i, bus.busy1, bus.busy2, busy_exp(bus.rd_addr1), busy_exp(bus.rd_addr2));
            end
            cyc();
            total++; if (bus.rd_data1 !== rd1_m || bus.rd_data2 !== rd2_m || bus.ready !== (clr == 0)) begin
                bad++; $display("FAIL rnd_data i=%0d got=%h/%h/%b exp=%h/%h/%b", i, bus.rd_data1, bus.rd_data2, bus.ready, rd1_m, rd2_m, clr == 0);
            end
        end
        rst = 0; idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;
        test_reset();
        test_latency();
        test_zero();
        test_scoreboard();
        test_bypass();
        test_lockout();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
